// File: rtl/alarm_comparators.sv
// ---------------------------------------------------------------------------
// alarm_comparators
//   Alarm-match stage between the per-day alarm registers and the alarm
//   driver.  It holds no alarm state of its own.  Each cycle it compares the
//   current time against all seven stored alarm times.  It then picks the
//   comparison for the current day and registers three outputs: a level
//   output, a rising-edge pulse and the raw match vector.
//
// Ports
//   clk        system clock, outputs update on rising edge
//   rst_n      asynchronous active-low reset
//   CT         current time word
//   CD         current day code (0..6 valid, 7 = invalid / never alarms)
//   Q_r0..6    stored alarm time for each day
//   AA         registered activate-alarm level
//   AA_rise    one-cycle pulse on AA 0->1
//   match      registered per-register equality vector, independent of CD
// ---------------------------------------------------------------------------
module alarm_comparators #(
    parameter int TIME_W   = 13,
    parameter int NUM_DAYS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TIME_W-1:0]   CT,
    input  logic [2:0]          CD,
    input  logic [TIME_W-1:0]   Q_r0,
    input  logic [TIME_W-1:0]   Q_r1,
    input  logic [TIME_W-1:0]   Q_r2,
    input  logic [TIME_W-1:0]   Q_r3,
    input  logic [TIME_W-1:0]   Q_r4,
    input  logic [TIME_W-1:0]   Q_r5,
    input  logic [TIME_W-1:0]   Q_r6,
    output logic                AA,
    output logic                AA_rise,
    output logic [NUM_DAYS-1:0] match
);

    logic [NUM_DAYS-1:0][TIME_W-1:0] q_arr;
    logic [NUM_DAYS-1:0]             eq;
    // Padded to 8 entries so that CD = 7 selects a constant zero.
    logic [7:0]                      eq_ext;
    logic                            sel;

    logic                aa_d, aa_q;
    logic                aa_rise_d, aa_rise_q;
    logic [NUM_DAYS-1:0] match_d, match_q;

    assign q_arr = {Q_r6, Q_r5, Q_r4, Q_r3, Q_r2, Q_r1, Q_r0};

    // Exact full-width compare per register; no masking of any bit.
    for (genvar i = 0; i < NUM_DAYS; i++) begin : g_cmp
        assign eq[i] = (CT == q_arr[i]);
    end

    assign eq_ext = {{(8-NUM_DAYS){1'b0}}, eq};

    always_comb begin
        sel       = eq_ext[CD];
        match_d   = eq;
        aa_d      = sel;
        // Compares against the previous registered AA, so the pulse fires
        // once per contiguous match interval.
        aa_rise_d = sel & ~aa_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aa_q      <= 1'b0;
            aa_rise_q <= 1'b0;
            match_q   <= '0;
        end else begin
            aa_q      <= aa_d;
            aa_rise_q <= aa_rise_d;
            match_q   <= match_d;
        end
    end

    assign AA      = aa_q;
    assign AA_rise = aa_rise_q;
    assign match   = match_q;

endmodule

// File: tb/tb_alarm_comparators.sv
module tb_alarm_comparators;

    logic        clk;
    logic        rst_n;
    logic [12:0] CT;
    logic [2:0]  CD;
    logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
    logic        AA, AA_rise;
    logic [6:0]  match;

    int n_cmp = 0;
    int n_bad = 0;

    alarm_comparators #(.TIME_W(13), .NUM_DAYS(7)) dut (
        .clk(clk), .rst_n(rst_n), .CT(CT), .CD(CD),
        .Q_r0(Q_r0), .Q_r1(Q_r1), .Q_r2(Q_r2), .Q_r3(Q_r3),
        .Q_r4(Q_r4), .Q_r5(Q_r5), .Q_r6(Q_r6),
        .AA(AA), .AA_rise(AA_rise), .match(match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check all three outputs at once.
    task automatic chk3(input string tag, input logic aa, input logic rise, input logic [6:0] m);
        check({tag, ".AA"}, {31'b0, AA}, {31'b0, aa});
        check({tag, ".AA_rise"}, {31'b0, AA_rise}, {31'b0, rise});
        check({tag, ".match"}, {25'b0, match}, {25'b0, m});
    endtask

    // Advance to the next rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [12:0] qv [7];

    initial begin
        Q_r0 = 13'h1FFF; Q_r1 = 13'h1FFE; Q_r2 = 13'h1FFD; Q_r3 = 13'h1FFB;
        Q_r4 = 13'h1FF7; Q_r5 = 13'h1FEF; Q_r6 = 13'h1FDF;
        qv = '{13'h1FFF, 13'h1FFE, 13'h1FFD, 13'h1FFB, 13'h1FF7, 13'h1FEF, 13'h1FDF};
        CT = 13'h1FFF; CD = 3'd0; rst_n = 1'b0;

        // Reset holds outputs low even across clock edges.
        #2;  chk3("reset_t2", 1'b0, 1'b0, 7'b0);
        step(); step();
        chk3("reset_held", 1'b0, 1'b0, 7'b0);
        rst_n = 1'b1;

        step(); chk3("first_match", 1'b1, 1'b1, 7'b0000001);
        step(); chk3("first_hold", 1'b1, 1'b0, 7'b0000001);

        CD = 3'd1;
        step(); chk3("day_away", 1'b0, 1'b0, 7'b0000001);
        CT = 13'h1FFE;
        step(); chk3("day1_match", 1'b1, 1'b1, 7'b0000010);
        step(); chk3("day1_hold", 1'b1, 1'b0, 7'b0000010);

        CT = 13'h11FF;
        step(); chk3("near_11FF", 1'b0, 1'b0, 7'b0);
        CT = 13'h1E3F;
        step(); chk3("near_1E3F", 1'b0, 1'b0, 7'b0);
        CT = 13'h1FFB;
        step(); chk3("nonsel_r3", 1'b0, 1'b0, 7'b0001000);
        CT = 13'h1FF7;
        step(); chk3("nonsel_r4", 1'b0, 1'b0, 7'b0010000);

        CT = 13'h1FEF;
        step(); chk3("r5_cd1", 1'b0, 1'b0, 7'b0100000);
        CD = 3'd5;
        step(); chk3("r5_cd5", 1'b1, 1'b1, 7'b0100000);
        CT = 13'h107F;
        step(); chk3("r5_miss", 1'b0, 1'b0, 7'b0);

        // Invalid day never alarms; match still tracks each register.
        CD = 3'd7;
        for (int i = 0; i < 7; i++) begin
            CT = qv[i];
            step();
            chk3($sformatf("cd7_r%0d", i), 1'b0, 1'b0, 7'(1 << i));
        end

        // Asynchronous reset in the middle of a match interval.
        CD = 3'd0; CT = 13'h1FFF;
        step(); chk3("pre_async_rise", 1'b1, 1'b1, 7'b0000001);
        step(); chk3("pre_async_hold", 1'b1, 1'b0, 7'b0000001);
        #2; rst_n = 1'b0;
        #1; chk3("async_clear", 1'b0, 1'b0, 7'b0);
        rst_n = 1'b1;
        #1; chk3("async_released", 1'b0, 1'b0, 7'b0);
        step(); chk3("post_reset_rise", 1'b1, 1'b1, 7'b0000001);
        step(); chk3("post_reset_hold", 1'b1, 1'b0, 7'b0000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
